multicycle_datapath: RTL

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

---
 rtl/multicycle_pkg.sv | 37 +++
 rtl/mc_alu.sv | 49 ++++
 rtl/multicycle_datapath.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle datapath: FSM states, ALU op codes,
// instruction class codes and condition codes.
package multicycle_pkg;

  typedef logic [2:0] state_t;
  localparam state_t S_FETCH     = 3'd0;
  localparam state_t S_DECODE    = 3'd1;
  localparam state_t S_EXECUTE   = 3'd2;
  localparam state_t S_MEMACC    = 3'd3;
  localparam state_t S_WRITEBACK = 3'd4;

  typedef logic [3:0] alu_op_t;
  localparam alu_op_t ALU_AND = 4'b0000;
  localparam alu_op_t ALU_SUB = 4'b0010;
  localparam alu_op_t ALU_ADD = 4'b0100;
  localparam alu_op_t ALU_ORR = 4'b1100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Unlisted condition codes never pass.
  function automatic logic cond_pass(input logic [3:0] cond, input logic z);
    case (cond)
      COND_AL: return 1'b1;
      COND_EQ: return z;
      COND_NE: return ~z;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU: ADD/SUB/AND/ORR with NZCV; unknown op codes add.
module mc_alu
  import multicycle_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_t         op,
  output logic [XLEN-1:0] result,
  output logic [3:0]      nzcv
);

  logic [XLEN:0] sum_s;
  logic [XLEN:0] diff_s;
  logic          c_s;
  logic          v_s;

  // Result and flag selection; SUB carry is the inverted borrow.
  always_comb begin
    sum_s  = {1'b0, a} + {1'b0, b};
    diff_s = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
    result = sum_s[XLEN-1:0];
    c_s    = sum_s[XLEN];
    v_s    = (a[XLEN-1] == b[XLEN-1]) && (sum_s[XLEN-1] != a[XLEN-1]);
    case (op)
      ALU_SUB: begin
        result = diff_s[XLEN-1:0];
        c_s    = diff_s[XLEN];
        v_s    = (a[XLEN-1] != b[XLEN-1]) && (diff_s[XLEN-1] != a[XLEN-1]);
      end
      ALU_AND: begin
        result = a & b;
        c_s    = 1'b0;
        v_s    = 1'b0;
      end
      ALU_ORR: begin
        result = a | b;
        c_s    = 1'b0;
        v_s    = 1'b0;
      end
      default: begin
        result = sum_s[XLEN-1:0];
      end
    endcase
    nzcv = {result[XLEN-1], (result == {XLEN{1'b0}}), c_s, v_s};
  end

endmodule

// File: rtl/multicycle_datapath.sv
// Five-state multicycle processor datapath with a single memory port;
// R[NREG-1] aliases the PC and reads back as pc+4 during decode.
module multicycle_datapath
  import multicycle_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 16
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [3:0]      alu_flags,
  output logic            retired
);

  localparam logic [3:0] PC_IDX = 4'(NREG - 1);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      flags_q, flags_d;
  logic            retired_q, retired_d;
  logic [XLEN-1:0] rf_q [0:NREG-2];
  logic [XLEN-1:0] rf_d [0:NREG-2];

  logic [1:0]      opc_s;
  logic            is_load_s;
  logic [3:0]      ra1_s;
  logic [3:0]      ra2_s;
  logic [3:0]      rd_s;
  logic [XLEN-1:0] rd_a_s;
  logic [XLEN-1:0] rd_b_s;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] alu_b_s;
  alu_op_t         alu_op_s;
  logic [XLEN-1:0] alu_res_s;
  logic [3:0]      alu_nzcv_s;

  assign opc_s     = instr_q[27:26];
  assign is_load_s = instr_q[20];
  assign ra1_s     = instr_q[19:16];
  assign rd_s      = instr_q[15:12];

  // Second read port: stores read their data register from the Rd field.
  always_comb begin
    if (opc_s == OP_MEM) begin
      ra2_s = instr_q[15:12];
    end else begin
      ra2_s = instr_q[3:0];
    end
  end

  // Register read port A, with the PC alias.
  always_comb begin
    rd_a_s = '0;
    if (ra1_s == PC_IDX) begin
      rd_a_s = pc_q + XLEN'(4);
    end else if (int'(ra1_s) < NREG - 1) begin
      rd_a_s = rf_q[ra1_s];
    end else begin
      rd_a_s = '0;
    end
  end

  // Register read port B, with the PC alias.
  always_comb begin
    rd_b_s = '0;
    if (ra2_s == PC_IDX) begin
      rd_b_s = pc_q + XLEN'(4);
    end else if (int'(ra2_s) < NREG - 1) begin
      rd_b_s = rf_q[ra2_s];
    end else begin
      rd_b_s = '0;
    end
  end

  // Immediate extension by instruction class.
  always_comb begin
    case (opc_s)
      OP_DP:   imm_s = XLEN'(instr_q[7:0]);
      OP_MEM:  imm_s = XLEN'(instr_q[11:0]);
      OP_BR:   imm_s = {{(XLEN-26){instr_q[23]}}, instr_q[23:0], 2'b00};
      default: imm_s = '0;
    endcase
  end

  // ALU operand/op select: memory address generation always adds the offset.
  always_comb begin
    if (opc_s == OP_DP) begin
      alu_op_s = instr_q[24:21];
      alu_b_s  = instr_q[25] ? imm_q : b_q;
    end else begin
      alu_op_s = ALU_ADD;
      alu_b_s  = imm_q;
    end
  end

  mc_alu #(.XLEN(XLEN)) u_alu (
    .a      (a_q),
    .b      (alu_b_s),
    .op     (alu_op_s),
    .result (alu_res_s),
    .nzcv   (alu_nzcv_s)
  );

  // Control FSM and datapath register next-state.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    res_d     = res_q;
    addr_d    = addr_q;
    flags_d   = flags_q;
    retired_d = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          instr_d = mem_rdata[31:0];
          pc_d    = pc_q + XLEN'(4);
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        a_d   = rd_a_s;
        b_d   = rd_b_s;
        imm_d = imm_s;
        if (cond_pass(instr_q[31:28], flags_q[2])) begin
          state_d = S_EXECUTE;
        end else begin
          retired_d = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_EXECUTE: begin
        case (opc_s)
          OP_DP: begin
            res_d   = alu_res_s;
            flags_d = instr_q[20] ? alu_nzcv_s : flags_q;
            state_d = S_WRITEBACK;
          end
          OP_MEM: begin
            addr_d  = alu_res_s;
            state_d = S_MEMACC;
          end
          OP_BR: begin
            pc_d      = pc_q + XLEN'(4) + imm_q;
            retired_d = 1'b1;
            state_d   = S_FETCH;
          end
          default: begin
            retired_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMACC: begin
        if (mem_ready && is_load_s) begin
          res_d   = mem_rdata;
          state_d = S_WRITEBACK;
        end else if (mem_ready) begin
          retired_d = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_MEMACC;
        end
      end
      S_WRITEBACK: begin
        if (rd_s == PC_IDX) begin
          pc_d = res_q;
        end else begin
          pc_d = pc_q;
        end
        retired_d = 1'b1;
        state_d   = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Register-file write port; the PC alias is handled in the FSM.
  always_comb begin
    rf_d = rf_q;
    if (state_q == S_WRITEBACK && rd_s != PC_IDX && int'(rd_s) < NREG - 1) begin
      rf_d[rd_s] = res_q;
    end else begin
      rf_d = rf_q;
    end
  end

  // Datapath and control state; reset wins over any memory handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      instr_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      res_q     <= '0;
      addr_q    <= '0;
      flags_q   <= 4'b0000;
      retired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      res_q     <= res_d;
      addr_q    <= addr_d;
      flags_q   <= flags_d;
      retired_q <= retired_d;
    end
  end

  // Register file keeps its contents through reset but never commits during it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_q <= rf_q;
    end else begin
      rf_q <= rf_d;
    end
  end

  assign mem_req   = (state_q == S_FETCH) || (state_q == S_MEMACC);
  assign mem_we    = (state_q == S_MEMACC) && !is_load_s;
  assign mem_addr  = (state_q == S_FETCH) ? pc_q : addr_q;
  assign mem_wdata = b_q;
  assign pc        = pc_q;
  assign alu_flags = flags_q;
  assign retired   = retired_q;

endmodule
